// File: rtl/date_set_ctrl.sv
// date_set_ctrl
//   Set-mode controller for the day/month/year counter chain. MODE walks
//   year -> month -> day edit and then commits with a one-cycle LOAD of the
//   edited BCD date. UP/DOWN step the selected field with BCD wrap. While
//   editing, RUN_EN is low so the counters stay frozen.
//
//   Optional build macro: SET_TIMEOUT_EN
//     When defined, an idle timer aborts editing after TIMEOUT_SEC ENABLE
//     ticks without a button press. The abort returns to RUN, discards the
//     edits and issues no LOAD.
//
// Ports
//   CLK        system clock
//   RESET      synchronous reset, active-low
//   ENABLE     1 Hz one-cycle tick
//   BTN_MODE   enter / advance / commit pulse
//   BTN_UP     increment selected field pulse
//   BTN_DOWN   decrement selected field pulse
//   cur_year   live BCD year (3 digits)
//   cur_month  live BCD month
//   cur_day    live BCD day
//   RUN_EN     counter enable gate, 0 while editing or committing
//   LOAD       one-cycle load strobe to the counters
//   set_year   edited BCD year
//   set_month  edited BCD month
//   set_day    edited BCD day
//   field      0 none, 1 year, 2 month, 3 day
//   BLINK      toggles on each ENABLE while editing, 0 otherwise
//
// state     | meaning
// ----------+------------------------------------------------
// ST_RUN    | counters free-running, buttons except MODE ignored
// ST_YEAR   | editing year
// ST_MONTH  | editing month
// ST_DAY    | editing day
// ST_COMMIT | one cycle, LOAD asserted with the edited date
module date_set_ctrl #(
  parameter logic [11:0] YEAR_MAX = 12'h299
`ifdef SET_TIMEOUT_EN
  , parameter int TIMEOUT_SEC = 30
`endif
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        BTN_MODE,
  input  logic        BTN_UP,
  input  logic        BTN_DOWN,
  input  logic [11:0] cur_year,
  input  logic [7:0]  cur_month,
  input  logic [7:0]  cur_day,
  output logic        RUN_EN,
  output logic        LOAD,
  output logic [11:0] set_year,
  output logic [7:0]  set_month,
  output logic [7:0]  set_day,
  output logic [1:0]  field,
  output logic        BLINK
);

  typedef enum logic [2:0] {
    ST_RUN, ST_YEAR, ST_MONTH, ST_DAY, ST_COMMIT
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] year_nxt;
  logic [7:0]  month_nxt, day_nxt;
  logic        edit;
  logic        step_up, step_dn;
  logic        timeout;

  function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
    if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    else                return {v[7:4], v[3:0] + 4'h1};
  endfunction

  function automatic logic [7:0] bcd_dec2(input logic [7:0] v);
    if (v[3:0] == 4'h0) return {v[7:4] - 4'h1, 4'h9};
    else                return {v[7:4], v[3:0] - 4'h1};
  endfunction

  function automatic logic [11:0] year_inc(input logic [11:0] y);
    if (y == YEAR_MAX)         return 12'h000;
    else if (y[7:0] == 8'h99)  return {y[11:8] + 4'h1, 8'h00};
    else                       return {y[11:8], bcd_inc2(y[7:0])};
  endfunction

  function automatic logic [11:0] year_dec(input logic [11:0] y);
    if (y == 12'h000)          return YEAR_MAX;
    else if (y[7:0] == 8'h00)  return {y[11:8] - 4'h1, 8'h99};
    else                       return {y[11:8], bcd_dec2(y[7:0])};
  endfunction

  function automatic logic [7:0] month_inc(input logic [7:0] m);
    return (m == 8'h12) ? 8'h01 : bcd_inc2(m);
  endfunction

  function automatic logic [7:0] month_dec(input logic [7:0] m);
    return (m == 8'h01) ? 8'h12 : bcd_dec2(m);
  endfunction

  // 10*T+U is divisible by 4 exactly when 2*T+U is, so the tens parity
  // selects which units digits qualify.
  function automatic logic is_leap(input logic [11:0] y);
    logic lo_div4;
    if (y[4]) lo_div4 = (y[3:0] == 4'h2) || (y[3:0] == 4'h6);
    else      lo_div4 = (y[3:0] == 4'h0) || (y[3:0] == 4'h4) || (y[3:0] == 4'h8);
    return lo_div4 && ((y[7:0] != 8'h00) || (y[11:8] == 4'h0));
  endfunction

  function automatic logic [7:0] max_day(input logic [11:0] y, input logic [7:0] m);
    case (m)
      8'h02:                      return is_leap(y) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  // Valid BCD compares correctly as plain unsigned binary.
  function automatic logic [7:0] clamp_day(input logic [7:0] d, input logic [7:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  assign edit    = (state == ST_YEAR) || (state == ST_MONTH) || (state == ST_DAY);
  assign step_up = BTN_UP & ~BTN_DOWN;
  assign step_dn = BTN_DOWN & ~BTN_UP;

`ifdef SET_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_SEC + 1);
  logic [IW-1:0] idle_cnt;
  logic          any_btn;

  assign any_btn = BTN_MODE | BTN_UP | BTN_DOWN;
  assign timeout = edit & ENABLE & ~any_btn & (idle_cnt == IW'(1));

  // Down-counter reloaded by any button; the tick that finds it at 1 is
  // the TIMEOUT_SEC-th idle tick.
  always_ff @(posedge CLK) begin
    if (!RESET || !edit || any_btn) idle_cnt <= IW'(TIMEOUT_SEC);
    else if (ENABLE && (idle_cnt != '0)) idle_cnt <= idle_cnt - 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    year_nxt  = set_year;
    month_nxt = set_month;
    day_nxt   = set_day;
    case (state)
      ST_RUN: begin
        if (BTN_MODE) begin
          state_nxt = ST_YEAR;
          year_nxt  = cur_year;
          month_nxt = cur_month;
          day_nxt   = clamp_day(cur_day, max_day(cur_year, cur_month));
        end
      end
      ST_YEAR: begin
        if (BTN_MODE)     state_nxt = ST_MONTH;
        else if (step_up) year_nxt  = year_inc(set_year);
        else if (step_dn) year_nxt  = year_dec(set_year);
        day_nxt = clamp_day(set_day, max_day(year_nxt, set_month));
      end
      ST_MONTH: begin
        if (BTN_MODE)     state_nxt = ST_DAY;
        else if (step_up) month_nxt = month_inc(set_month);
        else if (step_dn) month_nxt = month_dec(set_month);
        day_nxt = clamp_day(set_day, max_day(set_year, month_nxt));
      end
      ST_DAY: begin
        if (BTN_MODE) state_nxt = ST_COMMIT;
        else if (step_up)
          day_nxt = (set_day == max_day(set_year, set_month)) ? 8'h01 : bcd_inc2(set_day);
        else if (step_dn)
          day_nxt = (set_day == 8'h01) ? max_day(set_year, set_month) : bcd_dec2(set_day);
      end
      ST_COMMIT: state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
    if (timeout) state_nxt = ST_RUN;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= ST_RUN;
      set_year  <= 12'h000;
      set_month <= 8'h01;
      set_day   <= 8'h01;
      BLINK     <= 1'b0;
    end else begin
      state     <= state_nxt;
      set_year  <= year_nxt;
      set_month <= month_nxt;
      set_day   <= day_nxt;
      if (!edit)       BLINK <= 1'b0;
      else if (ENABLE) BLINK <= ~BLINK;
    end
  end

  assign RUN_EN = (state == ST_RUN);
  assign LOAD   = (state == ST_COMMIT);

  always_comb begin
    field = 2'd0;
    case (state)
      ST_YEAR:  field = 2'd1;
      ST_MONTH: field = 2'd2;
      ST_DAY:   field = 2'd3;
      default:  field = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_date_set_ctrl.sv
module tb_date_set_ctrl;

  logic        CLK = 1'b0;
  logic        RESET, ENABLE, BTN_MODE, BTN_UP, BTN_DOWN;
  logic [11:0] cur_year;
  logic [7:0]  cur_month, cur_day;
  logic        RUN_EN, LOAD, BLINK;
  logic [11:0] set_year;
  logic [7:0]  set_month, set_day;
  logic [1:0]  field;

  int n_checks = 0;
  int n_err    = 0;
  int load_cnt = 0;
  int exp_loads = 0;

  date_set_ctrl dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
    .BTN_MODE(BTN_MODE), .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN),
    .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
    .RUN_EN(RUN_EN), .LOAD(LOAD),
    .set_year(set_year), .set_month(set_month), .set_day(set_day),
    .field(field), .BLINK(BLINK)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (LOAD === 1'b1) load_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic press(input logic m, input logic u, input logic d);
    BTN_MODE = m; BTN_UP = u; BTN_DOWN = d;
    @(posedge CLK);
    #1;
    BTN_MODE = 1'b0; BTN_UP = 1'b0; BTN_DOWN = 1'b0;
  endtask

  task automatic tick();
    ENABLE = 1'b1;
    @(posedge CLK);
    #1;
    ENABLE = 1'b0;
  endtask

  task automatic set_cur(input logic [11:0] y, input logic [7:0] m, input logic [7:0] d);
    cur_year = y; cur_month = m; cur_day = d;
  endtask

  initial begin
    RESET = 1'b0; ENABLE = 1'b0;
    BTN_MODE = 1'b0; BTN_UP = 1'b0; BTN_DOWN = 1'b0;
    set_cur(12'h123, 8'h05, 8'h17);
    cyc(3);
    chk("rst_run_en", RUN_EN, 1);
    chk("rst_load", LOAD, 0);
    chk("rst_field", field, 0);
    chk("rst_blink", BLINK, 0);
    chk("rst_year", set_year, 12'h000);
    chk("rst_month", set_month, 8'h01);
    chk("rst_day", set_day, 8'h01);
    RESET = 1'b1;
    cyc(1);

    // UP/DOWN in RUN ignored
    press(0, 1, 0);
    press(0, 0, 1);
    chk("run_up_ignored_day", set_day, 8'h01);
    chk("run_up_ignored_field", field, 0);

    // 2024-03-31 -> month down -> 29 Feb, commit
    set_cur(12'h024, 8'h03, 8'h31);
    press(1, 0, 0);
    chk("entry_field", field, 1);
    chk("entry_run_en", RUN_EN, 0);
    chk("entry_year", set_year, 12'h024);
    chk("entry_month", set_month, 8'h03);
    chk("entry_day", set_day, 8'h31);
    tick();
    chk("blink_on", BLINK, 1);
    chk("blink_run_en", RUN_EN, 0);
    tick();
    chk("blink_off", BLINK, 0);
    press(1, 0, 0);
    chk("month_field", field, 2);
    press(0, 0, 1);
    chk("mar_dn_month", set_month, 8'h02);
    chk("mar_dn_clamp", set_day, 8'h29);
    press(1, 0, 0);
    chk("day_field", field, 3);
    press(1, 0, 0);
    exp_loads++;
    chk("commit_load", LOAD, 1);
    chk("commit_field", field, 0);
    chk("commit_run_en", RUN_EN, 0);
    chk("commit_year", set_year, 12'h024);
    chk("commit_month", set_month, 8'h02);
    chk("commit_day", set_day, 8'h29);
    cyc(1);
    chk("post_commit_run_en", RUN_EN, 1);
    chk("post_commit_load", LOAD, 0);
    chk("post_commit_blink", BLINK, 0);
    chk("load_count_1", load_cnt, exp_loads);

    // year and month wrap
    set_cur(12'h299, 8'h12, 8'h31);
    press(1, 0, 0);
    chk("wrap_entry_year", set_year, 12'h299);
    press(0, 1, 0);
    chk("year_up_wrap", set_year, 12'h000);
    press(0, 0, 1);
    chk("year_dn_wrap", set_year, 12'h299);
    press(0, 0, 1);
    chk("year_dn_298", set_year, 12'h298);
    press(0, 1, 0);
    press(1, 0, 0);
    press(0, 1, 0);
    chk("month_up_wrap", set_month, 8'h01);
    press(0, 0, 1);
    chk("month_dn_wrap", set_month, 8'h12);
    press(1, 0, 0);
    press(1, 0, 0);
    exp_loads++;
    chk("wrap_commit_load", LOAD, 1);
    cyc(1);

    // century non-leap: 2100-02
    set_cur(12'h100, 8'h02, 8'h28);
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    press(0, 1, 0);
    chk("feb2100_up_wrap", set_day, 8'h01);
    press(0, 0, 1);
    chk("feb2100_dn_wrap", set_day, 8'h28);
    press(1, 0, 0);
    exp_loads++;
    cyc(1);

    // 2000 is leap, plus simultaneous-button rules
    set_cur(12'h000, 8'h02, 8'h28);
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    press(0, 1, 0);
    chk("feb2000_up_29", set_day, 8'h29);
    press(0, 1, 0);
    chk("feb2000_up_wrap", set_day, 8'h01);
    press(0, 1, 1);
    chk("up_dn_nochange", set_day, 8'h01);
    chk("up_dn_field", field, 3);
    press(1, 1, 0);
    exp_loads++;
    chk("mode_up_load", LOAD, 1);
    chk("mode_up_day", set_day, 8'h01);
    cyc(1);
    chk("load_count_4", load_cnt, exp_loads);

    // entry clamp, then reset mid-edit
    set_cur(12'h023, 8'h04, 8'h31);
    press(1, 0, 0);
    chk("entry_clamp_day", set_day, 8'h30);
    press(1, 0, 0); press(1, 0, 0);
    chk("pre_reset_field", field, 3);
    RESET = 1'b0;
    cyc(1);
    RESET = 1'b1;
    chk("midreset_field", field, 0);
    chk("midreset_run_en", RUN_EN, 1);
    chk("midreset_year", set_year, 12'h000);
    chk("midreset_day", set_day, 8'h01);
    cyc(2);
    chk("midreset_no_load", load_cnt, exp_loads);

    // year edit clamps 29 Feb to 28
    set_cur(12'h000, 8'h02, 8'h29);
    press(1, 0, 0);
    chk("leap_entry_day", set_day, 8'h29);
    press(0, 1, 0);
    chk("year_clamp_year", set_year, 12'h001);
    chk("year_clamp_day", set_day, 8'h28);

`ifdef SET_TIMEOUT_EN
    press(1, 0, 0);
    repeat (29) tick();
    chk("to_29_field", field, 2);
    press(0, 1, 0);
    repeat (29) tick();
    chk("to_restart_field", field, 2);
    tick();
    chk("to_field", field, 0);
    chk("to_run_en", RUN_EN, 1);
    cyc(2);
    chk("to_no_load", load_cnt, exp_loads);
`endif

    RESET = 1'b0;
    cyc(1);
    RESET = 1'b1;
    cyc(2);
    chk("final_load_count", load_cnt, exp_loads);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
